// File: rtl/lift_motor_driver.sv
// lift_motor_driver: hoist motor sequencer with brake hold, duty ramps, reversal dwell and sticky safety fault.
// Turns the controller's up/stop/door decisions into a registered duty, direction and brake, with a PWM gate decoded from them.
module lift_motor_driver #(
  parameter int DUTY_W            = 8,
  parameter int RAMP_STEP_CYCLES  = 1000,
  parameter int BRAKE_HOLD_CYCLES = 20000,
  parameter int DEADTIME_CYCLES   = 50000,
  parameter int TIMEOUT_CYCLES    = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_i,
  input  logic              stop_i,
  input  logic              door_i,
  input  logic              fault_clr_i,
  output logic              motor_dir_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              pwm_o,
  output logic              brake_o,
  output logic              moving_o,
  output logic              fault_o
);
  localparam logic [DUTY_W-1:0] DMAX = '1;
  localparam int C1   = (RAMP_STEP_CYCLES > BRAKE_HOLD_CYCLES) ? RAMP_STEP_CYCLES : BRAKE_HOLD_CYCLES;
  localparam int CMAX = (C1 > DEADTIME_CYCLES) ? C1 : DEADTIME_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  // Synchronizers come out of reset reading stop=1 so the motor cannot start before real inputs arrive.
  localparam logic [3:0] SYNC_RST = 4'b0100;

  typedef enum logic [2:0] {IDLE, RELEASE, ACCEL, RUN, DECEL, DWELL, FAULT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DUTY_W-1:0] duty_q, duty_d, pwm_cnt_q;
  logic              dir_q, dir_d, brake_q, brake_d, moving_q, moving_d, fault_q, fault_d;
  logic              up_s, stop_s, door_s, clr_s, step, halt, running, active;

  assign {up_s, stop_s, door_s, clr_s} = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= SYNC_RST;
      sync2_q   <= SYNC_RST;
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      dir_q     <= 1'b0;
      brake_q   <= 1'b1;
      moving_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= {up_i, stop_i, door_i, fault_clr_i};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      dir_q     <= dir_d;
      brake_q   <= brake_d;
      moving_q  <= moving_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    step    = cnt_q == CW'(RAMP_STEP_CYCLES - 1);
    halt    = stop_s || (up_s != dir_q);
    running = (state_q == ACCEL) || (state_q == RUN);
    active  = running || (state_q == DECEL);
    state_d = state_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q + 1'b1;
    tmo_d   = running ? tmo_q + 1'b1 : tmo_q;
    case (state_q)
      IDLE: if (!stop_s && !door_s) begin
        state_d = RELEASE;
        dir_d   = up_s;
      end
      RELEASE: if (stop_s || door_s) state_d = IDLE;
        else if (cnt_q == CW'(BRAKE_HOLD_CYCLES - 1)) begin
          state_d = ACCEL;
          tmo_d   = '0;
        end
      ACCEL: if (halt) state_d = DECEL;
        else if (step) begin
          duty_d  = (duty_q == DMAX) ? DMAX : duty_q + 1'b1;
          cnt_d   = '0;
          state_d = (duty_d == DMAX) ? RUN : ACCEL;
        end
      RUN: if (halt) state_d = DECEL;
      DECEL: if (duty_q == '0) state_d = DWELL;
        else if (step) begin
          duty_d  = duty_q - 1'b1;
          cnt_d   = '0;
          state_d = (duty_d == '0) ? DWELL : DECEL;
        end
      DWELL: if (cnt_q == CW'(DEADTIME_CYCLES - 1)) state_d = IDLE;
      FAULT: if (clr_s && stop_s && !door_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Safety faults override every other transition and skip the ramp-down.
    if ((active && door_s) || (running && tmo_q == TW'(TIMEOUT_CYCLES - 1))) state_d = FAULT;
    if (state_d != state_q) cnt_d = '0;
    moving_d = (state_d == ACCEL) || (state_d == RUN) || (state_d == DECEL);
    brake_d  = !(moving_d || state_d == RELEASE);
    fault_d  = state_d == FAULT;
    if (!moving_d) duty_d = '0;
  end

  assign motor_dir_o = dir_q;
  assign duty_o      = duty_q;
  assign brake_o     = brake_q;
  assign moving_o    = moving_q;
  assign fault_o     = fault_q;
  assign pwm_o       = !brake_q && (pwm_cnt_q < duty_q);
endmodule

// File: tb/tb_lift_motor_driver.sv
// tb_lift_motor_driver: random and scenario stimulus against a time-based reference of the hoist sequence.
// The reference tracks the current phase and elapsed cycles and derives duty from elapsed time arithmetic.
module tb_lift_motor_driver;
  localparam int DW = 4, RAMP = 2, HOLD = 4, DEAD = 8, TMO = 200, DMAX = 15;

  logic clk = 0, rst_n = 0, up_i = 0, stop_i = 1, door_i = 0, fault_clr_i = 0;
  logic motor_dir_o, pwm_o, brake_o, moving_o, fault_o;
  logic [DW-1:0] duty_o;
  int checks = 0, failures = 0;

  string m_mode = "idle";
  int m_t = 0, m_dir = 0, m_run = 0, m_base = 0, m_n = 0;
  logic [3:0] h1 = 4'b0100, h2 = 4'b0100;

  lift_motor_driver #(
    .DUTY_W(DW), .RAMP_STEP_CYCLES(RAMP), .BRAKE_HOLD_CYCLES(HOLD),
    .DEADTIME_CYCLES(DEAD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up_i(up_i), .stop_i(stop_i), .door_i(door_i),
    .fault_clr_i(fault_clr_i), .motor_dir_o(motor_dir_o), .duty_o(duty_o),
    .pwm_o(pwm_o), .brake_o(brake_o), .moving_o(moving_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_duty();
    if (m_mode == "accel") return (m_t / RAMP > DMAX) ? DMAX : m_t / RAMP;
    if (m_mode == "run") return DMAX;
    if (m_mode == "decel") return (m_base - m_t / RAMP < 0) ? 0 : m_base - m_t / RAMP;
    return 0;
  endfunction

  function automatic int m_moving();
    return int'(m_mode == "accel" || m_mode == "run" || m_mode == "decel");
  endfunction

  function automatic int m_brake();
    return int'(!m_moving() && m_mode != "release");
  endfunction

  task automatic model_reset();
    m_mode = "idle"; m_t = 0; m_dir = 0; m_run = 0; m_base = 0; m_n = 0;
    h1 = 4'b0100; h2 = 4'b0100;
  endtask

  task automatic model_step();
    bit up, st, dr, cl, tmo;
    int nt;
    string nm;
    {up, st, dr, cl} = h2;
    h2 = h1;
    h1 = {up_i, stop_i, door_i, fault_clr_i};
    nt = m_t + 1;
    nm = m_mode;
    tmo = (m_mode == "accel" || m_mode == "run") && (m_run + 1 == TMO);
    if (m_mode == "idle") begin
      if (!st && !dr) begin nm = "release"; m_dir = up; end
    end else if (m_mode == "release") begin
      if (st || dr) nm = "idle";
      else if (nt == HOLD) nm = "accel";
    end else if (m_mode == "accel") begin
      if (st || up != m_dir[0]) begin nm = "decel"; m_base = m_duty(); end
      else if (nt / RAMP >= DMAX) nm = "run";
    end else if (m_mode == "run") begin
      if (st || up != m_dir[0]) begin nm = "decel"; m_base = DMAX; end
    end else if (m_mode == "decel") begin
      if (m_base - nt / RAMP <= 0) nm = "dwell";
    end else if (m_mode == "dwell") begin
      if (nt == DEAD) nm = "idle";
    end else if (m_mode == "fault") begin
      if (cl && st && !dr) nm = "idle";
    end
    if ((m_moving() != 0 && dr) || tmo) nm = "fault";
    m_run = (m_mode == "release" && nm == "accel") ? 0 : (m_mode == "accel" || m_mode == "run") ? m_run + 1 : m_run;
    m_t = (nm == m_mode) ? nt : 0;
    m_mode = nm;
    m_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("duty", int'(duty_o), m_duty());
    check("brake", int'(brake_o), m_brake());
    check("moving", int'(moving_o), m_moving());
    check("fault", int'(fault_o), int'(m_mode == "fault"));
    check("dir", int'(motor_dir_o), m_dir);
    check("pwm", int'(pwm_o), int'(m_brake() == 0 && (m_n % (DMAX + 1)) < m_duty()));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input string m, input int bound);
    for (int i = 0; i < bound && m_mode != m; i++) tick();
    check({"reach_", m}, int'(m_mode == m), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_brake"}, int'(brake_o), 1);
    check({tag, "_duty"}, int'(duty_o), 0);
    check({tag, "_pwm"}, int'(pwm_o), 0);
    check({tag, "_moving"}, int'(moving_o), 0);
    check({tag, "_fault"}, int'(fault_o), 0);
    check({tag, "_dir"}, int'(motor_dir_o), 0);
  endtask

  initial begin
    int hi;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    model_reset();
    rst_n = 1;
    ticks(20);
    check("idle_brake", int'(brake_o), 1);

    stop_i = 0; up_i = 1;
    run_until("run", 60);
    hi = 0;
    for (int i = 0; i < 16; i++) begin tick(); hi += int'(pwm_o); end
    check("pwm_run_hi", hi, 15);

    stop_i = 1;
    run_until("idle", 60);
    check("stop_brake", int'(brake_o), 1);

    stop_i = 0; up_i = 1;
    run_until("run", 60);
    up_i = 0;
    run_until("release", 80);
    check("rev_dir", int'(motor_dir_o), 0);

    run_until("accel", 20);
    for (int i = 0; i < 40 && m_duty() != 5; i++) tick();
    check("door_at5", int'(duty_o), 5);
    door_i = 1;
    ticks(3);
    check("door_fault", int'(fault_o), 1);
    check("door_duty", int'(duty_o), 0);
    stop_i = 1; fault_clr_i = 1;
    tick();
    fault_clr_i = 0;
    ticks(5);
    check("clr_ignored", int'(fault_o), 1);
    door_i = 0;
    ticks(3);
    fault_clr_i = 1;
    tick();
    fault_clr_i = 0;
    ticks(4);
    check("clr_ok", int'(fault_o), 0);

    stop_i = 0; up_i = 1;
    run_until("accel", 30);
    ticks(199);
    check("tmo_early", int'(fault_o), 0);
    tick();
    check("tmo_at", int'(fault_o), 1);
    check("tmo_brake", int'(brake_o), 1);
    ticks(50);
    stop_i = 1; fault_clr_i = 1;
    ticks(4);
    fault_clr_i = 0;
    ticks(4);

    stop_i = 0; up_i = 0;
    ticks(40);
    rst_n = 0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1;
    ticks(5);

    for (int s = 0; s < 60; s++) begin
      up_i = 1'($urandom_range(0, 1));
      stop_i = ($urandom_range(0, 3) == 0);
      door_i = ($urandom_range(0, 11) == 0);
      fault_clr_i = ($urandom_range(0, 4) == 0);
      ticks($urandom_range(1, 40));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
